uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. Data width, bit period, parity mode and stop-bit count are configurable. A small synchronous FIFO absorbs bursts from the producer. Sits between an on-chip byte producer (valid/ready) and the serial tx pin; frames go out back-to-back with no idle gap while the FIFO holds data.

## Interface
- DATA_BITS, 8: payload bits per frame, 5..8.
- CLKS_PER_BIT, 25: clk cycles per serial bit, ≥2.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries, power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  DATA_BITS  word to send, LSB first.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO not full; transfer on in_valid && in_ready at a rising edge.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  frame in progress or FIFO non-empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Reset values:
  - tx=1, busy=0, level=0, in_ready=1.
  - FIFO flushed; controller in IDLE.
  - Pushes during rst are ignored.
- Frame format, in order:
  - start bit (0);
  - DATA_BITS data bits, LSB first;
  - parity bit if PARITY≠0 (even: XOR of data; odd: inverted XOR);
  - STOP_BITS stop bits (1).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: (1+DATA_BITS+(PARITY≠0)+STOP_BITS)·CLKS_PER_BIT cycles.
- State machine:
  - IDLE: if FIFO non-empty, pop, load shift register, compute parity, tx←0 → START.
  - START → DATA after the bit period.
  - DATA shifts out DATA_BITS bits, then → PARITY (if enabled) or STOP.
  - PARITY → STOP after one bit period.
  - STOP holds tx=1 for STOP_BITS periods. At the end, if FIFO non-empty: pop and tx←0 on the same edge, → START (no gap). Otherwise → IDLE.
- Counters:
  - bit-period counter 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary;
  - bit index counter, cleared on each state change.
- FIFO:
  - Push and pop in the same cycle are legal when not full; level unchanged.
  - When full, in_ready=0 and no push, even if a pop occurs that cycle (no bypass).
  - There is no empty-bypass: every word passes through the FIFO.
- Reset mid-frame: partial frame abandoned, tx=1 on the next edge, FIFO contents discarded.

## Timing
- A word accepted at edge E0 into an empty FIFO with the controller in IDLE is popped at E1; tx=0 from E1.
- The first data bit appears at E1+CLKS_PER_BIT.
- in_ready and level update on the edge following a push or pop.
- busy is 1 from the edge after acceptance until the edge that returns the controller to IDLE with the FIFO empty.
- Sustained throughput: one word per frame length.
- With continuous in_valid from empty, FIFO_DEPTH+1 words are accepted before in_ready first drops.

## Structure
- Package uart_pkg:
  - parity_e (NONE, EVEN, ODD);
  - tx_state_e (IDLE, START, DATA, PARITY, STOP);
  - frame-length helper function.
- Sub-module uart_fifo: parametrised synchronous FIFO with push/pop/full/empty/level.
- Top level holds the controller, counters and shift register.
- Elaboration-time checks on parameter ranges.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → tx=1, level=0, in_ready=1, busy=0; no word enqueued.
- 8N1, CLKS_PER_BIT=4, send 0xA5 → tx pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; start bit at E1.
- 7E1, send 0x55 → parity bit 0. 7O1, send 0x55 → parity bit 1. 5N2, send 0x1F → two stop bits, 32 cycles with CLKS_PER_BIT=4.
- Burst: in_valid continuously high, FIFO_DEPTH=4, words 0x01..0x06 → 5 accepted, then in_ready=0 until the first frame ends. Frames are contiguous and in order; level never exceeds 4.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF with 2 words queued → tx=1 next edge, level=0. After release, no frame is sent until a new push.
- Random 200 words with random in_valid gaps → a scoreboard-decoded serial stream matches the input order; no glitch on tx within a bit period.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the parametrised UART transmitter
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   function automatic int frame_clks(input int data_bits, input int clks_per_bit,
                                     input int parity, input int stop_bits);
      return (1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy count, no bypass paths
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable framing
module uart_tx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 25,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   import uart_pkg::*;

   localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam bit HAS_PAR = (PARITY != int'(PAR_NONE));
   localparam bit ODD_PAR = (PARITY == int'(PAR_ODD));

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..8");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   tx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 pop, load, bit_end;
   logic                 fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid),
      .data_i  (in_data),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign in_ready = !fifo_full;
   assign tx       = tx_q;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;

   always_comb begin
      state_d   = state_q;
      cnt_d     = bit_end ? '0 : cnt_q + CW'(1);
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      load      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            load  = !fifo_empty;
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               tx_d      = shreg_q[0];
               shreg_d   = shreg_q >> 1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                  bit_idx_d = '0;
                  if (HAS_PAR) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d   = ST_STOP;
               bit_idx_d = '0;
               tx_d      = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                  // Chain straight into the next start bit when a word is waiting.
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d   = ST_IDLE;
                     bit_idx_d = '0;
                     tx_d      = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (load) begin
         pop       = 1'b1;
         shreg_d   = fifo_data;
         par_d     = ODD_PAR ? ~^fifo_data : ^fifo_data;
         tx_d      = 1'b0;
         state_d   = ST_START;
         cnt_d     = '0;
         bit_idx_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int L     = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, tx, busy;
   logic [2:0] level;

   logic [6:0] e_data = '0;
   logic [4:0] f_data = '0;
   logic       x_valid = 1'b0;
   logic       rdy_e, tx_e, busy_e, rdy_o, tx_o, busy_o, rdy_n, tx_n, busy_n;
   logic [2:0] level_e, level_o, level_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .tx(tx), .busy(busy), .level(level));

   uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
      .clk(clk), .rst(rst), .in_data(e_data), .in_valid(x_valid), .in_ready(rdy_e),
      .tx(tx_e), .busy(busy_e), .level(level_e));

   uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
      .clk(clk), .rst(rst), .in_data(e_data), .in_valid(x_valid), .in_ready(rdy_o),
      .tx(tx_o), .busy(busy_o), .level(level_o));

   uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n (
      .clk(clk), .rst(rst), .in_data(f_data), .in_valid(x_valid), .in_ready(rdy_n),
      .tx(tx_n), .busy(busy_n), .level(level_n));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: queue of words plus position inside the current frame.
   logic [7:0] mq[$];
   logic [7:0] expq[$];
   logic [9:0] fr = 10'h3ff;
   int         pos = -1;
   bit         model_ok = 1'b0;

   initial begin
      logic [7:0] w;
      bit         do_push;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq.delete();
            expq.delete();
            pos = -1;
            model_ok = 1'b1;
         end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            if ((pos < 0 || pos == L - 1) && mq.size() > 0) begin
               w   = mq.pop_front();
               fr  = {1'b1, w, 1'b0};
               pos = 0;
            end else if (pos == L - 1) begin
               pos = -1;
            end else if (pos >= 0) begin
               pos++;
            end
            if (do_push) begin
               mq.push_back(in_data);
               expq.push_back(in_data);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("tx", tx, (pos < 0) ? 1'b1 : fr[pos / CPB]);
            chk("level", level, mq.size());
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("busy", busy, (pos >= 0) || (mq.size() > 0));
         end
      end
   end

   // Serial decoder: recovers words from tx by mid-bit sampling.
   initial begin
      int         dt;
      int         b;
      bit         dact;
      logic [7:0] dw;
      dact = 1'b0;
      dt = 0;
      dw = '0;
      forever begin
         @(negedge clk);
         if (rst || !model_ok) begin
            dact = 1'b0;
         end else if (!dact) begin
            if (tx === 1'b0) begin
               dact = 1'b1;
               dt = 0;
            end
         end else begin
            dt++;
            if (dt % CPB == CPB / 2) begin
               b = dt / CPB;
               if (b >= 1 && b <= 8) begin
                  dw[b-1] = tx;
               end else if (b == 9) begin
                  chk("dec_stop", tx, 1'b1);
                  if (expq.size() == 0) fail("dec_unexpected_frame");
                  else chk("dec_word", dw, expq.pop_front());
                  dact = 1'b0;
               end
            end
         end
      end
   end

   task automatic push(input logic [7:0] w);
      bit acc;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         acc = in_ready;
         @(negedge clk);
         if (acc) return;
      end
      fail("push_timeout");
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   logic [44:0] t0, te, to, tn, b0, be, bn;
   localparam logic [9:0] A5F = 10'b1101001010;

   initial begin
      int n;
      int drop;
      int lows;

      in_valid = 1'b1;
      in_data  = 8'h77;
      x_valid  = 1'b1;
      e_data   = 7'h11;
      f_data   = 5'h03;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      x_valid  = 1'b0;
      chk("rst_tx", tx, 1'b1);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      chk("rst_noenq_level", level, 0);
      chk("rst_noenq_busy", busy_n, 1'b0);

      in_data  = 8'hA5;
      in_valid = 1'b1;
      e_data   = 7'h55;
      f_data   = 5'h1F;
      x_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      x_valid  = 1'b0;
      for (int j = 0; j < 45; j++) begin
         t0[j] = tx;   te[j] = tx_e;   to[j] = tx_o;   tn[j] = tx_n;
         b0[j] = busy; be[j] = busy_e; bn[j] = busy_n;
         @(negedge clk);
      end
      chk("a5_no_bypass", t0[0], 1'b1);
      for (int k = 0; k < 40; k++) chk($sformatf("a5_cycle%0d", k), t0[1+k], A5F[k/4]);
      chk("a5_busy_last", b0[40], 1'b1);
      chk("a5_busy_end", b0[41], 1'b0);
      chk("7e1_start", te[3], 1'b0);
      chk("7e1_parity", te[35], 1'b0);
      chk("7e1_stop", te[39], 1'b1);
      chk("7e1_busy_end", {be[40], be[41]}, 2'b10);
      chk("7o1_parity", to[35], 1'b1);
      chk("7o1_stop", to[39], 1'b1);
      chk("5n2_start", tn[3], 1'b0);
      chk("5n2_d4", tn[23], 1'b1);
      chk("5n2_stop1", tn[27], 1'b1);
      chk("5n2_stop2", tn[31], 1'b1);
      chk("5n2_busy_end", {bn[32], bn[33]}, 2'b10);
      idle(5);

      in_data  = 8'h01;
      in_valid = 1'b1;
      n = 0;
      drop = -1;
      for (int c = 0; c < 300 && n < 6; c++) begin
         if (in_ready) n++;
         else if (drop < 0) drop = n;
         @(negedge clk);
         in_data = 8'(n + 1);
      end
      in_valid = 1'b0;
      chk("burst_drop_after", drop, 5);
      chk("burst_all_accepted", n, 6);
      idle(6 * L + 20);
      chk("burst_drained", expq.size(), 0);

      push(8'hFF);
      push(8'h02);
      push(8'h03);
      in_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("mid_level_queued", level, 2);
      chk("mid_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_tx", tx, 1'b1);
      chk("mid_level", level, 0);
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("mid_quiet_tx", lows, 0);
      chk("mid_quiet_busy", busy, 1'b0);

      for (int i = 0; i < 200; i++) begin
         push(8'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 120));
      end
      idle(6 * L + 20);
      chk("rand_drained", expq.size(), 0);
      chk("rand_idle_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      fail("global_timeout");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
